computador_sys: RTL and testbench
=================================

# computador_sys

Minimal 16-bit stored-program computer with a synchronous-write instruction/data memory, an 8×16 register file, a two-state fetch/execute controller and a registered output port. Program words are written through the external load port while reset is held. When reset is released, the core executes from address 0 until a halt instruction. Results leave the block only via `out` instructions, which drive `bus`.

## Interface
- Module name: `computador_sys`. There are no parameters: memory is 256×16 and the register file is 8×16.
- `clock` input, 1 bit. Single clock; all state changes on its rising edge.
- `resetn` input, 1 bit. Reset is synchronous and active-high: 1 = reset asserted, sampled at the rising edge of `clock`.
- `mem_wr` input, 1 bit. External memory write enable.
- `iin` input, 16 bits. External write data (program word).
- `endereco_ext` input, 16 bits. External write address; only bits [7:0] are used.
- `bus` output, 16 bits. Output register, loaded by `out`.

## Operation
- **Memory load**
  - On each rising edge with `mem_wr`=1: mem[`endereco_ext`[7:0]] <= `iin`.
  - This applies regardless of reset or CPU state.
  - Memory is never cleared by reset.
- **Instruction fields**
  - Opcode op = [15:13]; rX = [12:10]; rY = [9:7]; imm10 = [9:0].
  - imm10 is sign-extended to 16 bits wherever it is used.
- **Opcodes**
  - 000 `add`: rX <= rX + rY, modulo 2^16.
  - 001 `sub`: rX <= rX − rY, modulo 2^16.
  - 010 `mv`: rX <= rY.
  - 011 `hlt`: enter HALT.
  - 100 `out`: `bus` <= rX.
  - 101 `ldi`: rX <= sext(imm10).
  - 110 `bez`: if rX == 0, pc <= A + sext(imm10), where A is the address of the `bez` word itself; otherwise fall through.
  - 111: no-op.
- Bits not used by an opcode are don't-care; x/z in them must not affect the result.
- r0 is an ordinary writable register.
- No flags; `bez` tests the register value directly.
- **State machine**
  - FETCH: IR <= mem[pc]; A <= pc; pc <= pc + 1 (8-bit, wraps 255→0); next state is EXEC.
  - EXEC: perform the IR operation; next state is FETCH, or HALT for `hlt`.
  - HALT: no state change; stays in HALT until reset.
- **Reset** (`resetn`=1 at an edge), effective from any state, including mid-instruction or during HALT:
  - pc = 0, state = FETCH.
  - All registers = 0.
  - `bus` = 0.
  - IR and A = 0.

## Timing
- Memory read is combinational (asynchronous); writes are synchronous.
- If an external write and a FETCH hit the same address at the same edge, the fetch gets the old word.
- Each instruction takes exactly 2 cycles (FETCH + EXEC), including taken and untaken `bez`.
- Counting cycle 1 as the first edge with `resetn`=0, instruction k completes at edge 2k.
- A register written in EXEC is visible to the next instruction.
- `bus` updates on the EXEC edge of `out` and holds its value until the next `out` or reset.
- Branch targets wrap modulo 256 and are taken at the EXEC edge; the next FETCH uses the target.
- `hlt`: HALT is entered at its EXEC edge. Afterwards pc, registers and `bus` stay frozen; external memory writes still work.

## Test plan
- **Load-and-run.** Hold `resetn`=1 and `mem_wr`=1 and load addresses 0..10 with:
  - ldi r0,0; ldi r1,1; ldi r2,5; ldi r3,3; ldi r4,0;
  - bez r3,+4; add r4,r2; sub r3,r1; bez r0,−3;
  - out r4; hlt.
  - Then drop `mem_wr` and `resetn`.
  - Required: `bus`=0x0000 until edge 38, then 0x000F; HALT at edge 40; `bus` stays 0x000F thereafter.
- **Reset values.** Assert `resetn`=1 for one edge mid-program. Required: `bus`=0; execution restarts at address 0; memory intact; the rerun gives the same result.
- **Arithmetic wrap.** Program ldi r1,0; ldi r2,1; sub r1,r2; out r1. Required: `bus`=0xFFFF.
- **Sign extension.** Program ldi r5,0x3FF; out r5. Required: `bus`=0xFFFF. Then ldi r5,0x1FF; out r5. Required: `bus`=0x01FF.
- **Untaken branch.** Program ldi r1,1; bez r1,+5; out r1. Required: `bus`=0x0001 at edge 6.
- **Halt freeze.** Program hlt; out r0 with r0 nonzero via a prior ldi. Required: `bus` never changes after HALT. An external write during HALT succeeds and is verified after a rerun.

Source files
------------

// File: rtl/computador_sys.sv
// Minimal 16-bit stored-program computer: 256x16 memory, 8x16 register file,
// fetch/execute controller and a registered output port loaded by `out`.
module computador_sys (
   input  logic        clock,
   input  logic        resetn,
   input  logic        mem_wr,
   input  logic [15:0] iin,
   input  logic [15:0] endereco_ext,
   output logic [15:0] bus
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MV  = 3'b010;
   localparam logic [2:0] OP_HLT = 3'b011;
   localparam logic [2:0] OP_OUT = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_BEZ = 3'b110;

   logic [15:0] mem_q [256];
   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];
   logic [1:0]  state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  a_q, a_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] bus_q, bus_d;

   logic [2:0]  op;
   logic [2:0]  rx;
   logic [2:0]  ry;
   logic [15:0] imm_sext;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^endereco_ext[15:8];

   assign op       = ir_q[15:13];
   assign rx       = ir_q[12:10];
   assign ry       = ir_q[9:7];
   assign imm_sext = {{6{ir_q[9]}}, ir_q[9:0]};

   // Memory is deliberately outside reset so a program loaded under reset survives.
   always_ff @(posedge clock) begin
      if (mem_wr) begin
         mem_q[endereco_ext[7:0]] <= iin;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      ir_d    = ir_q;
      bus_d   = bus_q;
      regs_d  = regs_q;
      case (state_q)
         ST_FETCH: begin
            ir_d    = mem_q[pc_q];
            a_d     = pc_q;
            pc_d    = pc_q + 8'd1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (op)
               OP_ADD: regs_d[rx] = regs_q[rx] + regs_q[ry];
               OP_SUB: regs_d[rx] = regs_q[rx] - regs_q[ry];
               OP_MV:  regs_d[rx] = regs_q[ry];
               OP_HLT: state_d    = ST_HALT;
               OP_OUT: bus_d      = regs_q[rx];
               OP_LDI: regs_d[rx] = imm_sext;
               OP_BEZ: begin
                  // Branch offset is relative to the bez word itself; 8-bit add wraps.
                  if (regs_q[rx] == 16'd0) begin
                     pc_d = a_q + imm_sext[7:0];
                  end
               end
               default: ;
            endcase
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q <= ST_FETCH;
         pc_q    <= 8'd0;
         a_q     <= 8'd0;
         ir_q    <= 16'd0;
         bus_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         ir_q    <= ir_d;
         bus_q   <= bus_d;
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      always_ff @(posedge clock) begin
         if (resetn) begin
            regs_q[gi] <= 16'd0;
         end else begin
            regs_q[gi] <= regs_d[gi];
         end
      end
   end

   assign bus = bus_q;

endmodule

// File: tb/tb_computador_sys.sv
// Self-checking bench for computador_sys: directed programs plus random programs,
// each checked edge by edge against an instruction-level reference model.
module tb_computador_sys;

   logic        clock;
   logic        resetn;
   logic        mem_wr;
   logic [15:0] iin;
   logic [15:0] endereco_ext;
   logic [15:0] bus;

   int total;
   int bad;

   logic [15:0] mdl_mem [256];
   logic [15:0] exp_bus [0:255];
   logic [15:0] obs_bus [0:255];

   computador_sys dut (
      .clock        (clock),
      .resetn       (resetn),
      .mem_wr       (mem_wr),
      .iin          (iin),
      .endereco_ext (endereco_ext),
      .bus          (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] enc_rr(input int op, input int rx, input int ry);
      logic [15:0] w;
      w = '0;
      w[15:13] = op[2:0];
      w[12:10] = rx[2:0];
      w[9:7]   = ry[2:0];
      return w;
   endfunction

   function automatic logic [15:0] enc_i(input int op, input int rx, input int imm);
      logic [15:0] w;
      w = '0;
      w[15:13] = op[2:0];
      w[12:10] = rx[2:0];
      w[9:0]   = imm[9:0];
      return w;
   endfunction

   task automatic write_word(input int addr, input logic [15:0] data);
      mem_wr       = 1'b1;
      endereco_ext = {$urandom_range(0, 255) & 8'hFF, addr[7:0]};
      iin          = data;
      tick();
      mem_wr = 1'b0;
      mdl_mem[addr[7:0]] = data;
   endtask

   // Instruction-level model: each instruction costs one fetch edge and one exec edge.
   task automatic build_trace(input int n);
      logic [15:0] r [8];
      logic [15:0] w, b, sext;
      logic [7:0]  pc, a;
      bit          halted;
      int          e, x, y;
      for (int i = 0; i < 8; i++) r[i] = 16'd0;
      pc = 0; b = 0; halted = 0; e = 1;
      while (e <= n) begin
         if (halted) begin
            exp_bus[e] = b;
            e++;
         end else begin
            w  = mdl_mem[pc];
            a  = pc;
            pc = pc + 8'd1;
            exp_bus[e] = b;
            e++;
            x    = int'(w[12:10]);
            y    = int'(w[9:7]);
            sext = {{6{w[9]}}, w[9:0]};
            case (w[15:13])
               3'd0: r[x] = r[x] + r[y];
               3'd1: r[x] = r[x] - r[y];
               3'd2: r[x] = r[y];
               3'd3: halted = 1;
               3'd4: b = r[x];
               3'd5: r[x] = sext;
               3'd6: if (r[x] == 16'd0) pc = a + sext[7:0];
               default: ;
            endcase
            if (e <= n) exp_bus[e] = b;
            e++;
         end
      end
   endtask

   task automatic run_check(input string tag, input int n);
      build_trace(n);
      resetn = 1'b1;
      tick();
      check({tag, "_rst"}, bus, 16'h0000);
      resetn = 1'b0;
      for (int e = 1; e <= n; e++) begin
         tick();
         obs_bus[e] = bus;
         check($sformatf("%s_e%0d", tag, e), bus, exp_bus[e]);
      end
      $display("run %s: cycles=%0d final bus=%h", tag, n, bus);
   endtask

   task automatic load_prog(input logic [15:0] prog [$]);
      resetn = 1'b1;
      foreach (prog[i]) write_word(i, prog[i]);
   endtask

   initial begin
      logic [15:0] prog [$];
      total = 0; bad = 0;
      resetn = 1'b1; mem_wr = 1'b0; iin = '0; endereco_ext = '0;
      tick();
      for (int a = 0; a < 256; a++) write_word(a, 16'hE000);

      // Load-and-run: 5*3 by repeated addition.
      prog = {enc_i(5,0,0), enc_i(5,1,1), enc_i(5,2,5), enc_i(5,3,3), enc_i(5,4,0),
              enc_i(6,3,4), enc_rr(0,4,2), enc_rr(1,3,1), enc_i(6,0,10'h3FD),
              enc_rr(4,4,0), enc_rr(3,0,0)};
      load_prog(prog);
      run_check("loop", 60);
      check("loop_e37", obs_bus[37], 16'h0000);
      check("loop_e38", obs_bus[38], 16'h000F);
      check("loop_e60", obs_bus[60], 16'h000F);

      // Reset mid-program, then the rerun must reproduce the result.
      resetn = 1'b0;
      for (int e = 0; e < 3; e++) tick();
      run_check("midrst_a", 20);
      resetn = 1'b1;
      tick();
      check("midrst_bus", bus, 16'h0000);
      run_check("midrst_b", 44);
      check("midrst_e38", obs_bus[38], 16'h000F);

      prog = {enc_i(5,1,0), enc_i(5,2,1), enc_rr(1,1,2), enc_rr(4,1,0), enc_rr(3,0,0)};
      load_prog(prog);
      run_check("wrap", 14);
      check("wrap_e8", obs_bus[8], 16'hFFFF);

      prog = {enc_i(5,5,10'h3FF), enc_rr(4,5,0), enc_i(5,5,10'h1FF), enc_rr(4,5,0), enc_rr(3,0,0)};
      load_prog(prog);
      run_check("sext", 14);
      check("sext_e4", obs_bus[4], 16'hFFFF);
      check("sext_e8", obs_bus[8], 16'h01FF);

      prog = {enc_i(5,1,1), enc_i(6,1,5), enc_rr(4,1,0), enc_rr(3,0,0)};
      load_prog(prog);
      run_check("untaken", 12);
      check("untaken_e6", obs_bus[6], 16'h0001);

      // Halt freeze, then patch the hlt word while halted and rerun.
      prog = {enc_i(5,0,7), enc_rr(3,0,0), enc_rr(4,0,0), enc_rr(3,0,0)};
      load_prog(prog);
      run_check("halt", 12);
      check("halt_e12", obs_bus[12], 16'h0000);
      write_word(1, enc_rr(4,0,0));
      for (int e = 0; e < 4; e++) tick();
      check("halt_wr_frozen", bus, 16'h0000);
      run_check("halt_rerun", 12);
      check("halt_rerun_e4", obs_bus[4], 16'h0007);

      // Random programs; stray instructions anywhere in memory are covered by the model.
      for (int t = 0; t < 4; t++) begin
         prog = {};
         for (int i = 0; i < 24; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:13] == 3'd3 && i < 20) w[15:13] = 3'd4;
            prog.push_back(w);
         end
         load_prog(prog);
         run_check($sformatf("rand%0d", t), 100);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
